alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning command buffer entries (power of two, >=2).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_op input 4, cmd_a input 8 and cmd_b input 8, forming the command handshake (op, operand A, operand B).
REQ-005 The block SHALL have ports alu_a output 8, alu_b output 8 and alu_ctrl output 4 driving the downstream combinational ALU (A, B, ALU_Control).
REQ-006 The block SHALL have port alu_result  input  8  the combinational Result returned by the ALU.
REQ-007 The block SHALL have ports res_valid output 1, res_ready input 1, res_data output 8 and res_op output 4 (op echo), forming the result handshake.
REQ-008 The block SHALL have ports busy output 1 and done_count output 8 (completed results, modulo 256).

Function
REQ-009 Commands SHALL be stored in a FIFO of FIFO_DEPTH entries {op,a,b}, with cmd_ready = !full and a push on cmd_valid && cmd_ready.
REQ-010 The FSM SHALL have exactly three states, IDLE, EXEC and HOLD.
REQ-011 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into the operand registers and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-012 In EXEC (one cycle), alu_a/alu_b/alu_ctrl SHALL equal the operand registers, and at the closing edge alu_result SHALL be registered into res_data, op into res_op, res_valid set to 1, and the FSM SHALL go to HOLD.
REQ-013 In HOLD, res_valid, res_data and res_op SHALL stay stable until res_valid && res_ready.
REQ-014 On the HOLD handshake, res_valid SHALL drop to 0, done_count SHALL increment, and the FSM SHALL pop the next entry and go to EXEC if the FIFO is non-empty, else go to IDLE.
REQ-015 Latency SHALL be as follows: command accepted at edge T, popped at T+1, res_valid high after T+2.
REQ-016 Sustained throughput with res_ready held high SHALL be one result per 2 cycles.
REQ-017 alu_a/alu_b/alu_ctrl SHALL hold their last operand values outside EXEC (no glitching to other values).
REQ-018 An empty FIFO SHALL NOT deliver a command for pop in the same cycle it is pushed (no bypass).
REQ-019 Push and pop in the same cycle on a non-empty FIFO SHALL both occur and leave the count unchanged.
REQ-020 A full FIFO SHALL deassert cmd_ready, and cmd_ready SHALL reassert the cycle after a pop.
REQ-021 Read and write pointers SHALL wrap modulo FIFO_DEPTH, using an extra bit or count to disambiguate full from empty.
REQ-022 done_count SHALL wrap 255 -> 0 without side effects.
REQ-023 busy SHALL equal (state != IDLE) || !empty.
REQ-024 All arithmetic SHALL be carried out by the ALU, with alu_result captured verbatim and no width extension.

Reset
REQ-025 While rst_n is low, the block SHALL hold: state = IDLE; FIFO empty (pointers 0); cmd_ready = 1 after reset release (0 during reset); res_valid = 0; res_data = 0; res_op = 0; alu_a = alu_b = 0; alu_ctrl = 0; done_count = 0; busy = 0.
REQ-026 Reset asserted mid-operation SHALL flush the FIFO and discard any in-flight or held result, with no res_valid pulse after release.

Structure
REQ-027 Package alu_issue_pkg SHALL hold DATA_W = 8, OP_W = 4, and the state typedef {IDLE, EXEC, HOLD}.
REQ-028 The block SHALL contain one sub-module, cmd_fifo (parameterised width OP_W+2*DATA_W and depth FIFO_DEPTH, async active-low reset).
REQ-029 The ALU SHALL NOT be instantiated inside this block.

Verification (bench ALU stub: alu_result = alu_a + alu_b, mod 256)
REQ-030 Single command: push op=4'b0000, a=8'h00, b=8'h01 at T, res_ready=1 -> res_valid high after T+2, res_data=8'h01, res_op=4'b0000, done_count=1.
REQ-031 Op sweep: a=8'h00, b=8'h01, ops 4'b0000..4'b1111 back-to-back -> 16 results in order, res_op echoes 0..15, alu_ctrl shows each op during its EXEC, done_count=16.
REQ-032 Backpressure/full: res_ready=0, push 6 commands (a=k, b=k) -> first 5 accepted (4 in FIFO + 1 held), cmd_ready low; res_data=8'h00 held stable; release res_ready -> results 0,2,4,6,8, then 6th accepted.
REQ-033 Overflow arithmetic: a=8'hFF, b=8'h02 -> res_data=8'h01 (no carry bit).
REQ-034 Wrap: 256 commands streamed -> done_count returns to 0.
REQ-035 Reset mid-HOLD: rst_n low while res_valid=1 with 2 queued -> res_valid=0 immediately, busy=0, no results after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared widths, FSM state type and the command record used by the ALU issue controller.
package alu_issue_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int CMD_W  = OP_W + 2*DATA_W;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and result handshakes between a requester and the ALU issue controller.
interface alu_issue_ctrl_if;
  import alu_issue_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [OP_W-1:0]   res_op;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_op
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_op
  );
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO, registered pointers with an extra wrap bit; no write-to-read bypass.
module cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Buffers ALU commands, drives one command per EXEC cycle into an external ALU, holds results for handshake.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic [7:0]        done_count
);
  state_t           state, state_n;
  cmd_t             head, opnd;
  logic [CMD_W-1:0] rdata;
  logic             full, empty, pop, push;

  // Gated by rst_n so the requester sees not-ready while reset is held.
  assign bus.cmd_ready = rst_n && !full;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = cmd_t'(rdata);

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_n = EXEC;
      end
      EXEC: state_n = HOLD;
      HOLD: if (bus.res_ready) begin
        pop     = !empty;
        state_n = empty ? IDLE : EXEC;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      opnd          <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_op    <= '0;
      done_count    <= '0;
    end else begin
      state <= state_n;
      if (pop) opnd <= head;
      if (state == EXEC) begin
        bus.res_data  <= alu_result;
        bus.res_op    <= opnd.op;
        bus.res_valid <= 1'b1;
      end else if (state == HOLD && bus.res_ready) begin
        bus.res_valid <= 1'b0;
        done_count    <= done_count + 8'd1;
      end
    end
  end

  // Operand registers only change on a pop, so the ALU inputs stay put outside EXEC.
  assign alu_a    = opnd.a;
  assign alu_b    = opnd.b;
  assign alu_ctrl = opnd.op;
  assign busy     = (state != IDLE) || !empty;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with an adder ALU stub, result scoreboard and directed corner cases.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [OP_W-1:0]   alu_ctrl;
  logic              busy;
  logic [7:0]        done_count;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .busy       (busy),
    .done_count (done_count)
  );

  assign alu_result = alu_a + alu_b;
  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] exp;
  } vec_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] model_done = 8'd0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample mid-cycle; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) check("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_data", bus.res_data, e.data);
          check("sb_op", bus.res_op, e.op);
          check("sb_alu_ctrl", alu_ctrl, e.op);
        end
        model_done = model_done + 8'd1;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_t e;
        e.op   = bus.cmd_op;
        e.data = bus.cmd_a + bus.cmd_b;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !bus.res_valid && sb.size() == 0) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vt[6];
    logic [7:0] d0;
    int seen;
    vt[0] = '{op: 4'h0, a: 8'h00, b: 8'h01, exp: 8'h01};
    vt[1] = '{op: 4'h3, a: 8'hFF, b: 8'h02, exp: 8'h01};
    vt[2] = '{op: 4'hF, a: 8'h80, b: 8'h80, exp: 8'h00};
    vt[3] = '{op: 4'h5, a: 8'h7F, b: 8'h01, exp: 8'h80};
    vt[4] = '{op: 4'h1, a: 8'h12, b: 8'h34, exp: 8'h46};
    vt[5] = '{op: 4'hA, a: 8'hFF, b: 8'hFF, exp: 8'hFE};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_op", bus.res_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_done_count", done_count, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    rst_n = 1'b1;
    #1 check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Single command latency: accepted at T, res_valid high after T+2
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    bus.cmd_op = 4'h0; bus.cmd_a = 8'h00; bus.cmd_b = 8'h01; bus.cmd_valid = 1'b1;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    check("lat_T_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    check("lat_T1_valid", bus.res_valid, 0);
    check("lat_T1_busy", busy, 1);
    @(posedge clk); #1;
    check("lat_T2_valid", bus.res_valid, 1);
    check("lat_T2_data", bus.res_data, 8'h01);
    check("lat_T2_op", bus.res_op, 0);
    @(posedge clk); #1;
    check("lat_T3_valid", bus.res_valid, 0);
    check("lat_done_count", done_count, 1);
    wait_drain();

    // Table vectors, including overflow without carry-out
    foreach (vt[i]) begin
      bit got = 0;
      send(vt[i].op, vt[i].a, vt[i].b);
      for (int c = 0; c < 20; c++) begin
        if (bus.res_valid) begin got = 1; break; end
        @(negedge clk);
      end
      check("vec_got_result", got, 1);
      check("vec_data", bus.res_data, vt[i].exp);
      check("vec_op", bus.res_op, vt[i].op);
      wait_drain();
    end
    check("vec_done_count", done_count, model_done);

    // Op sweep back-to-back
    d0 = model_done;
    for (int op = 0; op < 16; op++) send(4'(op), 8'h00, 8'h01);
    wait_drain();
    check("sweep_done_count", done_count, 8'(d0 + 8'd16));

    // Backpressure until full, then release
    bus.res_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(4'(k), 8'(k), 8'(k));
    bus.cmd_op = 4'h5; bus.cmd_a = 8'h05; bus.cmd_b = 8'h05; bus.cmd_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_cmd_ready", bus.cmd_ready, 0);
      check("full_res_valid", bus.res_valid, 1);
      check("full_res_data_stable", bus.res_data, 8'h00);
    end
    @(posedge clk); #1 bus.res_ready = 1'b1;
    @(posedge clk); #1;
    check("ready_reassert", bus.cmd_ready, 1);
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    wait_drain();
    check("full_done_count", done_count, model_done);

    // Reset while holding a result with two queued
    bus.res_ready = 1'b0;
    for (int k = 1; k < 4; k++) send(4'(k), 8'h01, 8'h01);
    check("pre_rst_valid", bus.res_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done_count", done_count, 0);
    check("mid_rst_res_data", bus.res_data, 0);
    sb.delete();
    model_done = 8'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    check("post_rst_no_result", seen, 0);
    check("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // 256 results wrap done_count back to zero
    for (int i = 0; i < 256; i++) send(4'(i), 8'(i), 8'h01);
    wait_drain();
    check("wrap_done_count", done_count, 0);
    check("wrap_model_count", model_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
